// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;
  typedef enum logic [1:0] {RUN, END, HALT} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;
  localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory, redirect and decode-side signals of the fetch sequencer.
interface fetch_sequencer_if;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        halted;
  logic [31:0] fetch_count;
  modport master (
    output imem_addr, imem_rd, dec_valid, dec_instr, dec_pc, halted, fetch_count,
    input  imem_data, redirect_valid, redirect_pc, dec_ready
  );
  modport slave (
    input  imem_addr, imem_rd, dec_valid, dec_instr, dec_pc, halted, fetch_count,
    output imem_data, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of {instr, pc} with flush; head is the oldest entry.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  entry_t     data_i,
  output entry_t     head_o,
  output logic [1:0] count_o
);
  entry_t     mem_q [BUF_DEPTH];
  logic       wr_q, rd_q;
  logic [1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) mem_q[wr_q] <= data_i;
      wr_q  <= wr_q ^ push_i;
      rd_q  <= rd_q ^ pop_i;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and imem read sequencer feeding decode through a 2-entry buffer.
// Optional FETCH_HALT_SENTINEL_EN: an all-ones fetched word ends fetch instead of being delivered.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned NUM_INSTR = 2,
  parameter logic [31:0] RESET_PC  = '0
) (
  input logic clk,
  input logic reset,
  fetch_sequencer_if.master bus
);
`ifdef FETCH_HALT_SENTINEL_EN
  localparam bit SENT_EN = 1'b1;
`else
  localparam bit SENT_EN = 1'b0;
`endif
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, tag_q, tag_d, cnt_q, cnt_d;
  logic        infl_q, infl_d;
  entry_t      head;
  logic [1:0]  occ, load, left;
  logic        pop, issue, resp, stop, push;
  fetch_buffer u_buf (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .data_i  ({bus.imem_data, tag_q}),
    .head_o  (head),
    .count_o (occ)
  );
  assign bus.dec_valid   = occ != 2'd0;
  assign bus.dec_instr   = head.instr;
  assign bus.dec_pc      = head.pc;
  assign bus.imem_addr   = pc_q;
  assign bus.imem_rd     = issue;
  assign bus.halted      = state_q == HALT;
  assign bus.fetch_count = cnt_q;
  assign pop   = bus.dec_valid && bus.dec_ready;
  // Occupancy the buffer will have once this cycle's pop and the inflight response settle.
  assign load  = occ - {1'b0, pop} + {1'b0, infl_q};
  assign issue = !reset && !bus.redirect_valid && state_q == RUN && pc_q < NUM_INSTR && !load[1];
  assign resp  = infl_q && !bus.redirect_valid;
  assign stop  = SENT_EN && resp && bus.imem_data == SENTINEL;
  assign push  = resp && !stop;
  assign left  = occ - {1'b0, pop} + {1'b0, push};
  always_comb begin
    pc_d    = bus.redirect_valid ? bus.redirect_pc : issue ? pc_q + 32'd1 : pc_q;
    infl_d  = issue && !stop;
    tag_d   = issue ? pc_q : tag_q;
    cnt_d   = pop ? cnt_q + 32'd1 : cnt_q;
    state_d = bus.redirect_valid ? (bus.redirect_pc >= NUM_INSTR ? END : RUN)
            : state_q == RUN ? ((stop || pc_q >= NUM_INSTR) ? END : RUN)
            : state_q == END ? (left == 2'd0 ? HALT : END)
            : HALT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tag_q   <= '0;
      infl_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of streaming, back-pressure, redirect, reset and sentinel behaviour.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   rds = 0;
  logic [31:0] m0 [4] = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003};
  logic [31:0] m1 [4] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h0C0C_0C0C, 32'h0};
  fetch_sequencer_if b0 ();
  fetch_sequencer_if b1 ();
  fetch_sequencer #(.NUM_INSTR(4), .RESET_PC(32'd0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  fetch_sequencer #(.NUM_INSTR(3), .RESET_PC(32'd0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (b0.imem_rd) b0.imem_data <= m0[b0.imem_addr[1:0]];
    if (b1.imem_rd) b1.imem_data <= m1[b1.imem_addr[1:0]];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask
  initial begin
    b0.dec_ready = 1'b1; b0.redirect_valid = 1'b0; b0.redirect_pc = '0;
    b1.dec_ready = 1'b1; b1.redirect_valid = 1'b0; b1.redirect_pc = '0;
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_rd", b0.imem_rd, 0);
    chk("rst_addr", b0.imem_addr, 0);
    chk("rst_valid", b0.dec_valid, 0);
    chk("rst_instr", b0.dec_instr, 0);
    chk("rst_pc", b0.dec_pc, 0);
    chk("rst_halted", b0.halted, 0);
    chk("rst_count", b0.fetch_count, 0);
    reset = 1'b0;
    #1;
    chk("c0_rd", b0.imem_rd, 1);
    chk("c0_addr", b0.imem_addr, 0);
    tick();
    chk("c1_valid", b0.dec_valid, 0);
    chk("c1_addr", b0.imem_addr, 1);
    tick();
    for (int c = 2; c <= 5; c++) begin
      chk("stream_valid", b0.dec_valid, 1);
      chk("stream_pc", b0.dec_pc, c - 2);
      chk("stream_instr", b0.dec_instr, m0[c-2]);
      chk("stream_halted", b0.halted, 0);
      if (c == 2) begin
        chk("sent_a_valid", b1.dec_valid, 1);
        chk("sent_a_instr", b1.dec_instr, m1[0]);
      end
`ifdef FETCH_HALT_SENTINEL_EN
      if (c == 3) chk("sent_drop", b1.dec_valid, 0);
      if (c == 4) chk("sent_halt_early", b1.halted, 1);
`else
      if (c == 3) chk("plain_ones_instr", b1.dec_instr, m1[1]);
      if (c == 4) chk("plain_c_pc", b1.dec_pc, 2);
`endif
      if (c == 5) chk("sent_halted", b1.halted, 1);
      tick();
    end
    chk("stream_halt", b0.halted, 1);
    chk("stream_drained", b0.dec_valid, 0);
    chk("stream_count", b0.fetch_count, 4);
`ifdef FETCH_HALT_SENTINEL_EN
    chk("sent_count", b1.fetch_count, 1);
`else
    chk("sent_count", b1.fetch_count, 3);
`endif
    b0.dec_ready = 1'b0;
    do_reset();
    rds = 0;
    for (int c = 0; c <= 5; c++) begin
      rds += int'(b0.imem_rd);
      if (c >= 2) begin
        chk("bp_valid", b0.dec_valid, 1);
        chk("bp_hold_instr", b0.dec_instr, m0[0]);
      end
      tick();
    end
    chk("bp_reads", rds, 2);
    b0.dec_ready = 1'b1;
    #1;
    for (int c = 6; c <= 9; c++) begin
      chk("bp_valid_rel", b0.dec_valid, 1);
      chk("bp_order_pc", b0.dec_pc, c - 6);
      chk("bp_order_instr", b0.dec_instr, m0[c-6]);
      tick();
    end
    chk("bp_halt", b0.halted, 1);
    chk("bp_count", b0.fetch_count, 4);
    do_reset();
    tick();
    tick();
    chk("rd_c2_pc", b0.dec_pc, 0);
    tick();
    b0.redirect_valid = 1'b1;
    b0.redirect_pc = 32'd1;
    #1;
    chk("rd_c3_pc", b0.dec_pc, 1);
    chk("rd_c3_noissue", b0.imem_rd, 0);
    tick();
    b0.redirect_valid = 1'b0;
    #1;
    chk("rd_c4_valid", b0.dec_valid, 0);
    chk("rd_c4_rd", b0.imem_rd, 1);
    chk("rd_c4_addr", b0.imem_addr, 1);
    tick();
    chk("rd_c5_valid", b0.dec_valid, 0);
    tick();
    chk("rd_c6_valid", b0.dec_valid, 1);
    chk("rd_c6_pc", b0.dec_pc, 1);
    chk("rd_c6_instr", b0.dec_instr, m0[1]);
    chk("rd_c6_count", b0.fetch_count, 2);
    tick();
    chk("rd_c7_pc", b0.dec_pc, 2);
    tick();
    chk("rd_c8_pc", b0.dec_pc, 3);
    tick();
    chk("rd_c9_halt", b0.halted, 1);
    chk("rd_c9_count", b0.fetch_count, 5);
    b0.redirect_valid = 1'b1;
    b0.redirect_pc = 32'd10;
    #1;
    chk("oor_t_rd", b0.imem_rd, 0);
    tick();
    b0.redirect_valid = 1'b0;
    #1;
    chk("oor_t1_halted", b0.halted, 0);
    chk("oor_t1_rd", b0.imem_rd, 0);
    tick();
    chk("oor_t2_halted", b0.halted, 1);
    chk("oor_count", b0.fetch_count, 5);
    do_reset();
    tick();
    tick();
    tick();
    chk("mr_c3_count", b0.fetch_count, 1);
    reset = 1'b1;
    #1;
    tick();
    chk("mr_valid", b0.dec_valid, 0);
    chk("mr_count", b0.fetch_count, 0);
    chk("mr_addr", b0.imem_addr, 0);
    chk("mr_halted", b0.halted, 0);
    reset = 1'b0;
    #1;
    chk("mr_restart_rd", b0.imem_rd, 1);
    chk("mr_restart_addr", b0.imem_addr, 0);
    tick();
    tick();
    chk("mr_c2_valid", b0.dec_valid, 1);
    chk("mr_c2_pc", b0.dec_pc, 0);
    chk("mr_c2_instr", b0.dec_instr, m0[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
